// File: rtl/riscv_mc_ctrl_if.sv
// Control bundle between the multi-cycle main controller and the datapath/memory port.
// The master side is the controller; the slave side is the datapath/memory.
interface riscv_mc_ctrl_if;
    logic [6:0] i_opcode;
    logic       i_br_taken;
    logic       i_mem_ack;
    logic       o_mem_req;
    logic       o_mem_we;
    logic       o_adr_src;
    logic       o_ir_we;
    logic       o_pc_we;
    logic       o_reg_we;
    logic [2:0] o_imm_src;
    logic [1:0] o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [1:0] o_alu_op;
    logic [1:0] o_result_src;
    logic       o_illegal;

    modport master (
        input  i_opcode, i_br_taken, i_mem_ack,
        output o_mem_req, o_mem_we, o_adr_src, o_ir_we, o_pc_we, o_reg_we,
               o_imm_src, o_alu_src_a, o_alu_src_b, o_alu_op, o_result_src, o_illegal
    );

    modport slave (
        output i_opcode, i_br_taken, i_mem_ack,
        input  o_mem_req, o_mem_we, o_adr_src, o_ir_we, o_pc_we, o_reg_we,
               o_imm_src, o_alu_src_a, o_alu_src_b, o_alu_op, o_result_src, o_illegal
    );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// RV32I multi-cycle main controller: FSM sequencing fetch/decode/execute/writeback.
// state    | meaning
// FETCH    | read instr at PC, PC+4 -> PC, load IR/oldPC on ack
// DECODE   | oldPC+imm -> ALUOut (branch/jump target), dispatch on opcode
// MEMADR   | rs1+imm address; MEMRD/MEMWR memory access; MEMWB load writeback
// EXE_R/I  | register / immediate ALU op; ALUWB writes ALUOut to rd
// JALR_ADR | rs1+imm target; JAL redirects PC, oldPC+4 -> ALUOut
// BRANCH   | compare rs1/rs2, load PC on taken; LUI writes imm to rd
module riscv_mc_ctrl (
    input  logic              i_clk,
    input  logic              i_rst,
    riscv_mc_ctrl_if.master   bus
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXE_R,
        S_EXE_I, S_ALUWB, S_JALR_ADR, S_JAL, S_BRANCH, S_LUI
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_imm_src;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        unique case (bus.i_opcode)
            OP_I, OP_LOAD, OP_JALR: w_imm_src = 3'd0;
            OP_STORE:               w_imm_src = 3'd1;
            OP_BR:                  w_imm_src = 3'd2;
            OP_LUI, OP_AUIPC:       w_imm_src = 3'd3;
            OP_JAL:                 w_imm_src = 3'd4;
            default:                w_imm_src = 3'd0;
        endcase
    end

    always_comb begin
        w_next           = r_state;
        bus.o_mem_req    = 1'b0;
        bus.o_mem_we     = 1'b0;
        bus.o_adr_src    = 1'b0;
        bus.o_ir_we      = 1'b0;
        bus.o_pc_we      = 1'b0;
        bus.o_reg_we     = 1'b0;
        bus.o_imm_src    = 3'd0;
        bus.o_alu_src_a  = 2'd0;
        bus.o_alu_src_b  = 2'd0;
        bus.o_alu_op     = 2'd0;
        bus.o_result_src = 2'd0;
        bus.o_illegal    = 1'b0;
        // Reset silences every strobe and select, including a pending request.
        if (i_rst) begin
            w_next = S_FETCH;
        end else begin
            bus.o_imm_src = w_imm_src;
            case (r_state)
                S_FETCH: begin
                    bus.o_mem_req    = 1'b1;
                    bus.o_alu_src_b  = 2'd2;
                    bus.o_result_src = 2'd2;
                    bus.o_ir_we      = bus.i_mem_ack;
                    bus.o_pc_we      = bus.i_mem_ack;
                    if (bus.i_mem_ack) w_next = S_DECODE;
                end
                S_DECODE: begin
                    bus.o_alu_src_a = 2'd1;
                    bus.o_alu_src_b = 2'd1;
                    case (bus.i_opcode)
                        OP_LOAD, OP_STORE: w_next = S_MEMADR;
                        OP_R:              w_next = S_EXE_R;
                        OP_I:              w_next = S_EXE_I;
                        OP_JAL:            w_next = S_JAL;
                        OP_JALR:           w_next = S_JALR_ADR;
                        OP_BR:             w_next = S_BRANCH;
                        OP_LUI:            w_next = S_LUI;
                        OP_AUIPC:          w_next = S_ALUWB;
                        OP_FENCE:          w_next = S_FETCH;
                        default: begin
                            bus.o_illegal = 1'b1;
                            w_next        = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    bus.o_alu_src_a = 2'd2;
                    bus.o_alu_src_b = 2'd1;
                    w_next = (bus.i_opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    bus.o_mem_req = 1'b1;
                    bus.o_adr_src = 1'b1;
                    if (bus.i_mem_ack) w_next = S_MEMWB;
                end
                S_MEMWB: begin
                    bus.o_result_src = 2'd1;
                    bus.o_reg_we     = 1'b1;
                    w_next           = S_FETCH;
                end
                S_MEMWR: begin
                    bus.o_mem_req = 1'b1;
                    bus.o_mem_we  = 1'b1;
                    bus.o_adr_src = 1'b1;
                    if (bus.i_mem_ack) w_next = S_FETCH;
                end
                S_EXE_R: begin
                    bus.o_alu_src_a = 2'd2;
                    bus.o_alu_op    = 2'd2;
                    w_next          = S_ALUWB;
                end
                S_EXE_I: begin
                    bus.o_alu_src_a = 2'd2;
                    bus.o_alu_src_b = 2'd1;
                    bus.o_alu_op    = 2'd3;
                    w_next          = S_ALUWB;
                end
                S_ALUWB: begin
                    bus.o_reg_we = 1'b1;
                    w_next       = S_FETCH;
                end
                S_JALR_ADR: begin
                    bus.o_alu_src_a = 2'd2;
                    bus.o_alu_src_b = 2'd1;
                    w_next          = S_JAL;
                end
                // Target already sits in ALUOut; ALU computes the link value meanwhile.
                S_JAL: begin
                    bus.o_alu_src_a = 2'd1;
                    bus.o_alu_src_b = 2'd2;
                    bus.o_pc_we     = 1'b1;
                    w_next          = S_ALUWB;
                end
                S_BRANCH: begin
                    bus.o_alu_src_a = 2'd2;
                    bus.o_alu_op    = 2'd1;
                    bus.o_pc_we     = bus.i_br_taken;
                    w_next          = S_FETCH;
                end
                S_LUI: begin
                    bus.o_result_src = 2'd3;
                    bus.o_reg_we     = 1'b1;
                    w_next           = S_FETCH;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: a driver walks each instruction's phase list and queues
// the expected output word per cycle; a negedge monitor pops and compares against the DUT.
module tb_riscv_mc_ctrl;
    typedef struct packed {
        logic       req;
        logic       we;
        logic       adr;
        logic       ir_we;
        logic       pc_we;
        logic       reg_we;
        logic [2:0] imm;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic [1:0] res;
        logic       ill;
    } vec_t;

    logic       clk;
    logic       rst;
    riscv_mc_ctrl_if bus();

    riscv_mc_ctrl dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    vec_t       exp_q[$];
    string      name_q[$];
    int         n_vec;
    int         n_err;
    logic [6:0] prev_opc;
    int         br_force;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d expected words still queued", exp_q.size());
        $fatal(1, "watchdog");
    end

    function automatic logic legal(input logic [6:0] opc);
        return opc inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                           7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111, 7'b0001111};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] opc);
        case (opc)
            7'b0100011:             return 3'd1;
            7'b1100011:             return 3'd2;
            7'b0110111, 7'b0010111: return 3'd3;
            7'b1101111:             return 3'd4;
            default:                return 3'd0;
        endcase
    endfunction

    function automatic vec_t exp_for(input string ph, input logic ack, input logic br,
                                     input logic [6:0] opc);
        vec_t v;
        v = '0;
        v.imm = imm_of(opc);
        case (ph)
            "fetch":    begin v.req = 1; v.b = 2; v.res = 2; v.ir_we = ack; v.pc_we = ack; end
            "decode":   begin v.a = 1; v.b = 1; v.ill = !legal(opc); end
            "memadr":   begin v.a = 2; v.b = 1; end
            "memrd":    begin v.req = 1; v.adr = 1; end
            "memwb":    begin v.res = 1; v.reg_we = 1; end
            "memwr":    begin v.req = 1; v.we = 1; v.adr = 1; end
            "exe_r":    begin v.a = 2; v.b = 0; v.op = 2; end
            "exe_i":    begin v.a = 2; v.b = 1; v.op = 3; end
            "aluwb":    begin v.reg_we = 1; end
            "jalr_adr": begin v.a = 2; v.b = 1; end
            "jal":      begin v.a = 1; v.b = 2; v.pc_we = 1; end
            "branch":   begin v.a = 2; v.op = 1; v.pc_we = br; end
            "lui":      begin v.res = 3; v.reg_we = 1; end
            default:    v = '0;
        endcase
        return v;
    endfunction

    task automatic do_cycle(input string ph, input logic r, input logic ack,
                            input logic [6:0] opc);
        logic br;
        @(posedge clk);
        #1;
        br = (br_force >= 0) ? br_force[0] : 1'($urandom_range(0, 1));
        rst            = r;
        bus.i_mem_ack  = ack;
        bus.i_br_taken = br;
        bus.i_opcode   = opc;
        exp_q.push_back(r ? vec_t'('0) : exp_for(ph, ack, br, opc));
        name_q.push_back(r ? "reset" : ph);
    endtask

    function automatic logic spur();
        return ($urandom_range(0, 3) == 0);
    endfunction

    task automatic run_instr(input logic [6:0] opc, input int wait_fix, input logic abort);
        string seq[$];
        int    w;
        w = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 3));
        repeat (w) do_cycle("fetch", 0, 0, prev_opc);
        do_cycle("fetch", 0, 1, prev_opc);
        do_cycle("decode", 0, spur(), opc);
        case (opc)
            7'b0000011: seq = '{"memadr", "memrd", "memwb"};
            7'b0100011: seq = '{"memadr", "memwr"};
            7'b0110011: seq = '{"exe_r", "aluwb"};
            7'b0010011: seq = '{"exe_i", "aluwb"};
            7'b1101111: seq = '{"jal", "aluwb"};
            7'b1100111: seq = '{"jalr_adr", "jal", "aluwb"};
            7'b1100011: seq = '{"branch"};
            7'b0110111: seq = '{"lui"};
            7'b0010111: seq = '{"aluwb"};
            default:    seq = {};
        endcase
        foreach (seq[k]) begin
            if (seq[k] == "memrd" || seq[k] == "memwr") begin
                w = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 3));
                if (abort && seq[k] == "memrd") begin
                    do_cycle("memrd", 0, 0, opc);
                    do_cycle("reset", 1, 1, opc);
                    do_cycle("reset", 1, 1'($urandom_range(0, 1)), opc);
                    prev_opc = opc;
                    return;
                end
                repeat (w) do_cycle(seq[k], 0, 0, opc);
                do_cycle(seq[k], 0, 1, opc);
            end else begin
                do_cycle(seq[k], 0, spur(), opc);
            end
        end
        prev_opc = opc;
    endtask

    always @(negedge clk) begin
        vec_t  e;
        vec_t  act;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = {bus.o_mem_req, bus.o_mem_we, bus.o_adr_src, bus.o_ir_we, bus.o_pc_we,
                   bus.o_reg_we, bus.o_imm_src, bus.o_alu_src_a, bus.o_alu_src_b,
                   bus.o_alu_op, bus.o_result_src, bus.o_illegal};
            n_vec++;
            if (act !== e) begin
                n_err++;
                $display("FAIL %s @%0t opc=%b: got req=%b we=%b adr=%b ir=%b pc=%b reg=%b imm=%0d a=%0d b=%0d op=%0d res=%0d ill=%b, want req=%b we=%b adr=%b ir=%b pc=%b reg=%b imm=%0d a=%0d b=%0d op=%0d res=%0d ill=%b",
                         nm, $time, bus.i_opcode,
                         act.req, act.we, act.adr, act.ir_we, act.pc_we, act.reg_we, act.imm,
                         act.a, act.b, act.op, act.res, act.ill,
                         e.req, e.we, e.adr, e.ir_we, e.pc_we, e.reg_we, e.imm,
                         e.a, e.b, e.op, e.res, e.ill);
            end
        end
    end

    initial begin
        logic [6:0] opc;
        logic [6:0] legal_ops [10];
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                      7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111, 7'b0001111};
        n_vec = 0;
        n_err = 0;
        br_force = -1;
        prev_opc = 7'b0010011;
        rst = 1'b1;
        bus.i_mem_ack  = 1'b0;
        bus.i_br_taken = 1'b0;
        bus.i_opcode   = prev_opc;
        do_cycle("reset", 1, 1, prev_opc);
        do_cycle("reset", 1, 0, prev_opc);

        run_instr(7'b0010011, 2, 0);            // ADDI
        run_instr(7'b0100011, 3, 0);            // SW
        br_force = 1;
        run_instr(7'b1100011, 0, 0);            // BEQ taken
        br_force = 0;
        run_instr(7'b1100011, 1, 0);            // BEQ not taken
        br_force = -1;
        run_instr(7'b1100111, 0, 0);            // JALR
        run_instr(7'b0110111, 0, 0);            // LUI
        run_instr(7'b0000000, 0, 0);            // illegal
        run_instr(7'b0001111, 1, 0);            // FENCE
        run_instr(7'b0000011, 2, 1);            // load aborted by reset in MEMRD
        run_instr(7'b0000011, 0, 0);            // first fetch after reset

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                opc = legal_ops[$urandom_range(0, 9)];
            end else begin
                opc = 7'($urandom());
                while (legal(opc)) opc = 7'($urandom());
            end
            run_instr(opc, -1, (opc == 7'b0000011) && ($urandom_range(0, 7) == 0));
        end

        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected words never compared, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
